fft_bitrev_reorder: RTL
=======================

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: bit width of the real and imaginary sample parts.
REQ-002 SHALL have parameter N_POINTS, default 16: frame length; power of two, at least 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_val, input, 1 bit: input sample valid; no backpressure on this side.
REQ-006 SHALL have port in_re, input, DATA_WIDTH bits: real part, two's complement, FFT output order (bit-reversed).
REQ-007 SHALL have port in_im, input, DATA_WIDTH bits: imaginary part, two's complement.
REQ-008 SHALL have port out_val, output, 1 bit: output sample valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accept; transfer occurs when out_val and out_ready are both 1.
REQ-010 SHALL have port out_re, output, DATA_WIDTH bits: real part, natural order.
REQ-011 SHALL have port out_im, output, DATA_WIDTH bits: imaginary part, natural order.
REQ-012 SHALL have port out_last, output, 1 bit: high with out_val on natural index N_POINTS-1.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when an input sample is dropped.

Function
REQ-014 SHALL hold two N_POINTS-entry banks (ping-pong), each with a full flag.
REQ-015 SHALL keep a write counter wr_cnt of log2(N_POINTS) bits; each accepted in_val writes {in_re,in_im} to write-bank address bitrev(wr_cnt), then increments wr_cnt.
REQ-016 SHALL, on the write with wr_cnt = N_POINTS-1, set that bank full, wrap wr_cnt to 0 and toggle the write bank.
REQ-017 SHALL drop in_val samples when the write bank is full, leave wr_cnt unchanged and set overflow.
REQ-018 SHALL read the full read bank at addresses 0..N_POINTS-1 in ascending order, advancing on each transfer.
REQ-019 SHALL assert out_val no later than 2 cycles after the edge that sets the read bank full, when out_ready was high.
REQ-020 SHALL hold out_re, out_im, out_last and out_val stable while out_val=1 and out_ready=0.
REQ-021 SHALL, on the transfer with out_last=1, clear that bank's full flag and toggle the read bank; the next frame's first sample follows on the next cycle when available.
REQ-022 SHALL sustain one sample per cycle for back-to-back frames with out_ready held high, without bubbles and without overflow.
REQ-023 SHALL allow a bank's full-clear and its reuse for writing in the same cycle, without a dropped sample.
REQ-024 SHALL contain only synchronous-read storage, so the banks can map to block RAM.

Reset
REQ-025 SHALL on rst=0 set out_val=0, out_last=0, out_re=0, out_im=0, overflow=0, wr_cnt=0, read index=0, both full flags=0 and both bank selects=bank 0.
REQ-026 SHALL discard any partial or pending frame on reset; bank contents need not be cleared.

Configuration
REQ-027 SHALL, when macro FFT_REORDER_IFFT_SCALE_EN is defined, right-shift out_re and out_im arithmetically by log2(N_POINTS), truncating toward minus infinity, for IFFT 1/N normalisation.
REQ-028 SHALL, when FFT_REORDER_IFFT_SCALE_EN is undefined, output stored samples unmodified, with no extra latency in either build.

Verification
REQ-029 SHALL cover: N=16, out_ready=1, in_re=0..15 on consecutive cycles, in_im=0 -> out_re sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; out_last only on the 16th output.
REQ-030 SHALL cover: 4 back-to-back frames, out_ready=1 -> 64 contiguous outputs, each frame correctly reordered, overflow=0.
REQ-031 SHALL cover: out_ready toggling 1010... during the read of frame 1, frame 2 still arriving -> outputs held stable while stalled, sequence intact, overflow=0.
REQ-032 SHALL cover: out_ready=0 while 3 full frames arrive -> first 2 frames kept, all of frame 3 dropped, overflow=1 until reset; after out_ready=1, frames 1 and 2 output correctly.
REQ-033 SHALL cover: rst pulse after 7 samples of a frame -> all outputs return to 0; a new 16-sample frame then reorders correctly starting from wr_cnt=0.
REQ-034 SHALL cover: with FFT_REORDER_IFFT_SCALE_EN defined, inputs re=160 and im=-16 -> out_re=10, out_im=-1; with it undefined -> out_re=160, out_im=-16.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer that turns bit-reversed FFT output into natural order.
// Samples are written at bitrev(wr_cnt) and read back at ascending addresses.
// Build option FFT_REORDER_IFFT_SCALE_EN: outputs are arithmetically shifted right by
// log2(N_POINTS) for IFFT 1/N normalisation (same latency as the default build).
module fft_bitrev_reorder #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N_POINTS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_val,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    output logic                  out_val,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    output logic                  out_last,
    output logic                  overflow
);
    localparam int AW = $clog2(N_POINTS);
    localparam int SW = 2 * DATA_WIDTH;
    localparam logic [AW-1:0] LastIdx = AW'(N_POINTS - 1);

    // Both banks live in one array addressed as {bank, addr}.
    logic [SW-1:0] mem [2*N_POINTS];

    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic [1:0]    full_q, full_d;
    logic          overflow_q, overflow_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic          rd_bank_q, rd_bank_d;    // bank currently being fetched
    logic          out_bank_q, out_bank_d;  // bank whose samples are being presented
    logic          out_val_q, out_val_d;
    logic          out_last_q, out_last_d;
    logic [SW-1:0] rdata_q, rdata_d;

    logic xfer, clr, wr_ok, fetch;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    // Handshake decode; a bank being released this cycle may be rewritten in the same cycle.
    always_comb begin
        xfer  = out_val_q & out_ready;
        clr   = xfer & out_last_q;
        wr_ok = in_val & (~full_q[wr_bank_q] | (clr & (out_bank_q == wr_bank_q)));
        // The read-data register doubles as the output stage, so fetch only when it frees up.
        fetch = full_q[rd_bank_q] & (~out_val_q | out_ready);
    end

    // Write side: counter, bank select, full flags and sticky overflow.
    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        full_d     = full_q;
        overflow_d = overflow_q;
        if (clr) begin
            full_d[out_bank_q] = 1'b0;
        end
        if (wr_ok) begin
            wr_cnt_d = wr_cnt_q + AW'(1);
            if (wr_cnt_q == LastIdx) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end else if (in_val) begin
            overflow_d = 1'b1;
        end
    end

    // Read side: synchronous fetch into the output register, held while stalled.
    always_comb begin
        rd_idx_d   = rd_idx_q;
        rd_bank_d  = rd_bank_q;
        out_bank_d = out_bank_q ^ clr;
        out_val_d  = out_val_q;
        out_last_d = out_last_q;
        rdata_d    = rdata_q;
        if (fetch) begin
            rdata_d    = mem[{rd_bank_q, rd_idx_q}];
            out_val_d  = 1'b1;
            out_last_d = (rd_idx_q == LastIdx);
            rd_idx_d   = rd_idx_q + AW'(1);
            if (rd_idx_q == LastIdx) begin
                rd_bank_d = ~rd_bank_q;
            end
        end else if (xfer) begin
            out_val_d  = 1'b0;
            out_last_d = 1'b0;
        end
    end

    // Sample storage: write port only, no reset so it can map to block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[{wr_bank_q, bitrev(wr_cnt_q)}] <= {in_re, in_im};
        end
    end

    // Control and output state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q   <= '0;
            wr_bank_q  <= 1'b0;
            full_q     <= '0;
            overflow_q <= 1'b0;
            rd_idx_q   <= '0;
            rd_bank_q  <= 1'b0;
            out_bank_q <= 1'b0;
            out_val_q  <= 1'b0;
            out_last_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            wr_bank_q  <= wr_bank_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            rd_idx_q   <= rd_idx_d;
            rd_bank_q  <= rd_bank_d;
            out_bank_q <= out_bank_d;
            out_val_q  <= out_val_d;
            out_last_q <= out_last_d;
            rdata_q    <= rdata_d;
        end
    end

    // Output drive; scaling is pure wiring so both builds share the same latency.
    always_comb begin
        out_val  = out_val_q;
        out_last = out_last_q;
        overflow = overflow_q;
`ifdef FFT_REORDER_IFFT_SCALE_EN
        out_re   = $signed(rdata_q[SW-1:DATA_WIDTH]) >>> AW;
        out_im   = $signed(rdata_q[DATA_WIDTH-1:0]) >>> AW;
`else
        out_re   = rdata_q[SW-1:DATA_WIDTH];
        out_im   = rdata_q[DATA_WIDTH-1:0];
`endif
    end

endmodule
